// File: rtl/jtframe_ps2_rx.sv
// PS/2 receive-only front end: synchronise, deglitch ps2_clk, deframe 11-bit frames.
// Optional macro JTFRAME_PS2_TIMEOUT_EN abandons frames after TIMEOUT idle clk cycles.
module jtframe_ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 48000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       error
);

  if (FILTER_LEN < 2 || FILTER_LEN > 32 || TIMEOUT < 1) begin : g_bad_param
    $error("jtframe_ps2_rx: FILTER_LEN must be 2..32 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]            clk_sync, dat_sync;
  logic [FILTER_LEN-1:0] hist;
  logic                  fclk, fclk_d, fall;

  // Sync FFs and filter preset to the idle-high line level
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      hist     <= '1;
      fclk     <= 1'b1;
      fclk_d   <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      hist     <= {hist[FILTER_LEN-2:0], clk_sync[1]};
      fclk_d   <= fclk;
      if (hist == '0)
        fclk <= 1'b0;
      else if (&hist)
        fclk <= 1'b1;
    end
  end

  assign fall = fclk_d & ~fclk;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [7:0] shift, shift_nxt, data_nxt;
  logic       par, par_nxt, valid_nxt, error_nxt;
  logic       to_hit;

`ifdef JTFRAME_PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  assign to_hit = (state != IDLE) && (to_cnt == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst || to_hit || state == IDLE || fclk != fclk_d)
      to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT))
      to_cnt <= to_cnt + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      shift <= '0;
      par   <= 1'b0;
      data  <= '0;
      valid <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shift <= shift_nxt;
      par   <= par_nxt;
      data  <= data_nxt;
      valid <= valid_nxt;
      error <= error_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_nxt = shift;
    par_nxt   = par;
    data_nxt  = data;
    valid_nxt = 1'b0;
    error_nxt = 1'b0;
    if (to_hit) begin
      state_nxt = IDLE;
      error_nxt = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: if (!dat_sync[1]) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
        end
        DATA: begin
          shift_nxt = {dat_sync[1], shift[7:1]};
          cnt_nxt   = cnt + 3'd1;
          if (cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_nxt   = dat_sync[1];
          state_nxt = STOP;
        end
        STOP: begin
          // odd parity: XOR over data and parity bit must be 1
          if (dat_sync[1] && (^shift ^ par)) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
          end else begin
            error_nxt = 1'b1;
          end
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_ps2_rx.sv
// Scoreboard bench for jtframe_ps2_rx: frames are pushed as expectations, strobes pop them.
module tb_jtframe_ps2_rx;
  localparam int FL = 8;
  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data;
  logic       valid, error;

  jtframe_ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data(data), .valid(valid), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {bit err; logic [7:0] d;} exp_t;
  exp_t sbq[$];
  int checks = 0, fails = 0;
  logic [7:0] exp_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input bit err, input logic [7:0] d);
    exp_t e;
    e.err = err;
    e.d   = d;
    sbq.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst) exp_data = 8'h00;
    else if (valid || error) begin
      if (sbq.size() == 0) chk("unexpected_strobe", {30'd0, valid, error}, 32'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("strobe_kind", {30'd0, valid, error}, e.err ? 32'd1 : 32'd2);
        if (!e.err) begin
          chk("data", {24'd0, data}, {24'd0, e.d});
          exp_data = e.d;
        end else
          chk("data_hold", {24'd0, data}, {24'd0, exp_data});
      end
    end
  end

  // Sends the first nbits of a frame at a 40-cycle half period
  task automatic send(input logic [7:0] b, input bit bad_par, input logic stop,
                      input bit glitch, input int nbits, input bit meas);
    logic [10:0] fr;
    fr = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      if (glitch && i >= 3 && i <= 5) begin
        cyc(10); ps2_clk = 1'b0; cyc(3); ps2_clk = 1'b1; cyc(7);
      end else
        cyc(20);
      ps2_clk = 1'b0;
      if (meas && i == 10) begin
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        repeat (40) begin
          @(posedge clk); #1;
          n++;
          if (!seen && (valid || error)) begin
            seen = 1;
            chk("latency", n, FL + 4);
          end
        end
        if (!seen) chk("strobe_seen", 0, 1);
      end else
        cyc(40);
      ps2_clk = 1'b1;
      cyc(20);
    end
  endtask

  initial begin
    cyc(5);
    rst = 1'b0;
    #0;
    chk("rst_data", {24'd0, data}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_error", {31'd0, error}, 0);
    cyc(10);

    push(0, 8'h1C); send(8'h1C, 0, 1'b1, 0, 11, 1);
    cyc(30);

    push(0, 8'hE0); push(0, 8'hF0);
    send(8'hE0, 0, 1'b1, 0, 11, 1);
    send(8'hF0, 0, 1'b1, 0, 11, 1);
    cyc(30);

    push(1, 8'h00); send(8'h1C, 1, 1'b1, 0, 11, 1);
    cyc(30);
    push(1, 8'h00); send(8'h1C, 0, 1'b0, 0, 11, 1);
    ps2_data = 1'b1;
    cyc(30);
    chk("data_after_err", {24'd0, data}, 32'hF0);

    push(0, 8'h75); send(8'h75, 0, 1'b1, 1, 11, 1);
    cyc(30);

    send(8'h00, 0, 1'b1, 0, 5, 0);
    ps2_data = 1'b1;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    #0;
    chk("abort_data", {24'd0, data}, 0);
    chk("abort_valid", {31'd0, valid}, 0);
    chk("abort_error", {31'd0, error}, 0);
    cyc(20);
    push(0, 8'h29); send(8'h29, 0, 1'b1, 0, 11, 1);
    cyc(30);

`ifdef JTFRAME_PS2_TIMEOUT_EN
    push(1, 8'h00);
    send(8'hFF, 0, 1'b1, 0, 4, 0);
    ps2_data = 1'b1;
    cyc(400);
    chk("timeout_drained", sbq.size(), 0);
    push(0, 8'h16); send(8'h16, 0, 1'b1, 0, 11, 1);
    cyc(30);
`endif

    cyc(50);
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
